// File: rtl/tuner_pkg.sv
// Shared tuner constants: spectrum RAM geometry, arbiter state encoding, requester ids.
// Pure declarations; no timing or flow-control behaviour of its own.
package tuner_pkg;
   localparam int ADDR_W        = 11;
   localparam int DATA_W        = 10;
   localparam int SPECTRUM_BINS = 1024;
   localparam int IMAG_OFFSET   = 1024;

   typedef enum logic {ARB, LOCKED} arb_state_t;

   localparam int REQ_FFT  = 0;
   localparam int REQ_PEAK = 1;
   localparam int REQ_DBG  = 2;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, as one-hot and as index.
// Purely combinational, zero latency; found=0 when no request is set.
module rr_pick
   import tuner_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [PTR_W-1:0] idx,
   output logic             found
);
   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      // Walk from the farthest offset back to ptr so the closest request wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req[j]) begin
            onehot    = '0;
            onehot[j] = 1'b1;
            idx       = PTR_W'(j);
            found     = 1'b1;
         end
      end
   end
endmodule

// File: rtl/spectrum_ram_arbiter.sv
// Round-robin arbiter for the single-port spectrum RAM with bounded lockable bursts.
// Grant and RAM drive are same-cycle; read data returns one cycle later; losers simply hold req.
module spectrum_ram_arbiter #(
   parameter int N_REQ     = 3,
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 10,
   parameter int MAX_BURST = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          lock,
   input  logic [N_REQ-1:0]          we,
   input  logic [N_REQ*ADDR_W-1:0]   addr,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic                      ram_we,
   output logic [DATA_W-1:0]         ram_wdata,
   input  logic [DATA_W-1:0]         ram_rdata
);
   import tuner_pkg::*;

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

   arb_state_t        state, state_nxt;
   logic [PTR_W-1:0]  ptr, ptr_nxt, owner, owner_nxt, sel, pick_idx;
   logic [CNT_W-1:0]  burst_cnt, cnt_nxt;
   logic [N_REQ-1:0]  pick_oh;
   logic              pick_found, granted;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] wdata_hold;

   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
      return (i == LAST) ? '0 : i + 1'b1;
   endfunction

   rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      cnt_nxt   = burst_cnt;
      gnt       = '0;
      sel       = owner;
      granted   = 1'b0;
      if (!rst) begin
         case (state)
            ARB: begin
               if (pick_found) begin
                  gnt     = pick_oh;
                  sel     = pick_idx;
                  granted = 1'b1;
                  if (lock[pick_idx] && MAX_BURST > 1) begin
                     state_nxt = LOCKED;
                     owner_nxt = pick_idx;
                     cnt_nxt   = CNT_W'(1);
                  end else begin
                     ptr_nxt = next_idx(pick_idx);
                  end
               end
            end
            LOCKED: begin
               // Owner going idle also ends the burst, so a stalled owner cannot park the RAM.
               state_nxt = ARB;
               ptr_nxt   = next_idx(owner);
               if (req[owner]) begin
                  gnt[owner] = 1'b1;
                  granted    = 1'b1;
                  cnt_nxt    = burst_cnt + 1'b1;
                  if (lock[owner] && (32'(burst_cnt) + 1 != MAX_BURST)) begin
                     state_nxt = LOCKED;
                     ptr_nxt   = ptr;
                  end
               end
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = addr_hold;
      ram_wdata = wdata_hold;
      if (rst) begin
         ram_addr  = '0;
         ram_wdata = '0;
      end else if (granted) begin
         ram_we    = we[sel];
         ram_addr  = addr[int'(sel)*ADDR_W +: ADDR_W];
         ram_wdata = wdata[int'(sel)*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB;
         ptr        <= '0;
         owner      <= '0;
         burst_cnt  <= '0;
         rvalid     <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         owner      <= owner_nxt;
         burst_cnt  <= cnt_nxt;
         rvalid     <= (granted && !we[sel]) ? gnt : '0;
         addr_hold  <= ram_addr;
         wdata_hold <= ram_wdata;
      end
   end

   assign rdata = ram_rdata;
endmodule
